mc_core_seq: RTL and testbench
==============================

Name: mc_core_seq

Overview:
Multi-cycle sequencer for the RV32 core. It replaces the single-cycle, zero-wait top-level datapath timing with an FSM that fetches, decodes, executes, accesses memory and writes back over several cycles. Instruction and data memory use req/ack handshakes, and a bus timeout detects stalled transfers. The existing decode, immediate, regfile and EX blocks remain combinational around it. This block owns the PC register, the instruction register, the memory address/data latches and the write-enable strobe.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 0, PC value loaded on reset
BUS_TIMEOUT, 255, cycles waiting for ack before fault; 0 disables timeout

Ports:
clk  in  1  core clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address (= pc)
imem_ack  in  1  fetch data valid
imem_rdata  in  32  fetched instruction
pc  out  XLEN  current PC
instr  out  32  instruction register
dec_mem_read  in  1  decoded load
dec_mem_write  in  1  decoded store
dec_reg_write  in  1  decoded rd write
alu_result_in  in  XLEN  EX result / memory address
rs2_in  in  XLEN  store data
pc_next_in  in  XLEN  next PC from branch/jump mux
dmem_req  out  1  data request
dmem_we  out  1  1 = store
dmem_addr  out  XLEN  latched address
dmem_wdata  out  XLEN  latched store data
dmem_ack  in  1  data transfer done
dmem_rdata  in  XLEN  load data
load_data  out  XLEN  latched load data for WB
rf_wen  out  1  regfile write strobe
retire  out  1  one-cycle pulse per completed instruction
halt_req  in  1  stop after current instruction
state  out  3  FSM state
fault  out  1  sticky bus/alignment fault

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, instr=32'h0000_0013, dmem_addr/dmem_wdata/load_data=0, timeout counter=0, fault=0. All strobes and requests are 0.
- IDLE -> FETCH on the first clock edge after reset release.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable.
  - Ack in the same cycle as req is accepted (zero-wait memory). On ack, instr<=imem_rdata and go to DECODE.
  - Acks seen in any other state are ignored.
- DECODE: one cycle, no outputs. Go to EXEC.
- EXEC:
  - dmem_addr<=alu_result_in, dmem_wdata<=rs2_in.
  - If dec_mem_read or dec_mem_write, go to MEM; else go to WB.
- MEM:
  - dmem_req=1; dmem_we=dec_mem_write. Address and data held stable.
  - On dmem_ack: load_data<=dmem_rdata if load. Go to WB.
- WB:
  - rf_wen=dec_reg_write for exactly this cycle.
  - retire=1; pc<=pc_next_in.
  - Next state is HALT if halt_req=1, else FETCH.
- HALT:
  - No requests are issued.
  - When halt_req=0, go to FETCH at the PC already updated in WB.
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments each cycle without ack.
  - When count==BUS_TIMEOUT and there is no ack (BUS_TIMEOUT≠0): go to FAULT and set fault=1. The request drops the next cycle.
- Alignment: in WB, if pc_next_in[1:0]≠0, then fault=1, go to FAULT, pc is not updated, and retire=0. rf_wen is still asserted, so the link write completes.
- FAULT is absorbing: no requests, rf_wen=0, retire=0. Only reset exits.
- Latency, zero-wait memories:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- Reset asserted mid-transfer: requests drop immediately (async), state=IDLE, and any pending ack is discarded.
- Decode inputs must be stable from DECODE through WB. instr is only written in FETCH, so this holds.

Test Plan:
- Reset release, imem_ack tied 1, instr=ADDI (reg_write=1), pc_next_in=pc+4 -> retire every 4 cycles; pc 0→4→8; rf_wen pulses in WB only.
- LW with dmem_ack delayed 3 cycles, dmem_rdata=32'hDEAD_BEEF -> dmem_req high 4 cycles with constant dmem_addr; load_data=32'hDEAD_BEEF in WB; 8 cycles total.
- SW -> dmem_we=1 and dmem_wdata=rs2_in during MEM; rf_wen=0; retire=1.
- imem_ack never asserted, BUS_TIMEOUT=4 -> FAULT after 5 FETCH cycles; fault=1 and imem_req=0 thereafter; reset clears it.
- halt_req=1 during an instruction -> retire, then HALT (state=6) with no requests; deassert -> FETCH at pc_next_in.
- pc_next_in=32'h0000_0006 in WB -> fault=1, pc unchanged, retire=0. Separately, async reset asserted during MEM -> dmem_req=0 immediately, state=0.

Source files
------------

// File: rtl/mc_core_seq.sv
// Multi-cycle sequencer for the RV32 core.
// Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB,
// talking to instruction/data memories over req/ack handshakes. Owns the
// PC, the instruction register, the data-memory address/data latches, the
// load-data latch and the register-file write strobe. A per-transfer
// watchdog and a PC alignment check drive a sticky fault state.
module mc_core_seq #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter int               BUS_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    // instruction memory
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    // architectural state towards decode / EX
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr,
    // decoded control and EX results
    input  logic            dec_mem_read,
    input  logic            dec_mem_write,
    input  logic            dec_reg_write,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [XLEN-1:0] pc_next_in,
    // data memory
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    // write-back and status
    output logic [XLEN-1:0] load_data,
    output logic            rf_wen,
    output logic            retire,
    input  logic            halt_req,
    output logic [2:0]      state,
    output logic            fault
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    // Canonical NOP (addi x0, x0, 0) so decode sees a harmless word out of reset.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Watchdog counter only needs to reach BUS_TIMEOUT.
    localparam int            TW       = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LIMIT = TW'(BUS_TIMEOUT);
    localparam bit            TO_EN    = (BUS_TIMEOUT != 0);

    logic [2:0]      state_q,  state_d;
    logic [XLEN-1:0] pc_q,     pc_d;
    logic [31:0]     instr_q,  instr_d;
    logic [XLEN-1:0] addr_q,   addr_d;
    logic [XLEN-1:0] wdata_q,  wdata_d;
    logic [XLEN-1:0] ldata_q,  ldata_d;
    logic [TW-1:0]   cnt_q,    cnt_d;
    logic            fault_q,  fault_d;

    logic            pc_aligned;
    logic            timed_out;

    assign pc_aligned = (pc_next_in[1:0] == 2'b00);
    assign timed_out  = TO_EN && (cnt_q == TO_LIMIT);

    // Next-state logic for the sequencer, latches and watchdog.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers latches.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ldata_d = ldata_q;
        fault_d = fault_q;
        // Counter is zero in every non-waiting state, so it starts from zero
        // whenever FETCH or MEM is entered.
        cnt_d   = '0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                addr_d  = alu_result_in;
                wdata_d = rs2_in;
                state_d = (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (dec_mem_read) begin
                        ldata_d = dmem_rdata;
                    end
                    state_d = S_WB;
                end else if (timed_out) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_WB: begin
                // A misaligned target must not become the architectural PC.
                if (!pc_aligned) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    pc_d    = pc_next_in;
                    state_d = halt_req ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (!halt_req) begin
                    state_d = S_FETCH;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // State and datapath registers; async reset drops requests at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the datapath latches are reset too, because load_data and
            // dmem_addr/dmem_wdata are visible outputs with defined reset values.
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            addr_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Strobes decode straight from the current state.
    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = (state_q == S_MEM) && dec_mem_write;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign load_data  = ldata_q;
    // Link write still completes on a misaligned jump; only retire is withheld.
    assign rf_wen     = (state_q == S_WB) && dec_reg_write;
    assign retire     = (state_q == S_WB) && pc_aligned;
    assign pc         = pc_q;
    assign instr      = instr_q;
    assign state      = state_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_mc_core_seq.sv
// Directed bench for mc_core_seq: per-cycle state/strobe checks with a
// scoreboard of expected write-back results per instruction.
module tb_mc_core_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_reg_write;
    logic [31:0] alu_result_in;
    logic [31:0] rs2_in;
    logic [31:0] pc_next_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data;
    logic        rf_wen;
    logic        retire;
    logic        halt_req;
    logic [2:0]  state;
    logic        fault;

    always #5 clk = ~clk;

    mc_core_seq #(
        .XLEN        (32),
        .RESET_PC    (32'h0),
        .BUS_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .instr         (instr),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_reg_write (dec_reg_write),
        .alu_result_in (alu_result_in),
        .rs2_in        (rs2_in),
        .pc_next_in    (pc_next_in),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .load_data     (load_data),
        .rf_wen        (rf_wen),
        .retire        (retire),
        .halt_req      (halt_req),
        .state         (state),
        .fault         (fault)
    );

    typedef struct {
        logic        rf_wen;
        logic        retire;
        logic        chk_load;
        logic [31:0] load_data;
        logic [31:0] pc_after;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_pc;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic quiet(input string tag);
        check({tag, ".retire"}, retire, 0);
        check({tag, ".rf_wen"}, rf_wen, 0);
    endtask

    // Runs one instruction from its first FETCH cycle through WB.
    task automatic do_instr(input logic [31:0] ins, input logic rd, input logic wr,
                            input logic rw, input int iwait, input int dwait,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input logic [31:0] nxt,
                            input logic halt);
        exp_t e;
        e.rf_wen    = rw;
        e.retire    = (nxt[1:0] == 2'b00);
        e.chk_load  = rd;
        e.load_data = rdata;
        e.pc_after  = e.retire ? nxt : model_pc;
        sb_q.push_back(e);

        for (int i = 0; i <= iwait; i++) begin
            @(negedge clk);
            if (i == 0) begin
                dec_mem_read  = rd;
                dec_mem_write = wr;
                dec_reg_write = rw;
                alu_result_in = addr;
                rs2_in        = sdata;
                halt_req      = 1'b0;
            end
            imem_ack   = (i == iwait);
            imem_rdata = ins;
            #1;
            check("fetch.state", state, 1);
            check("fetch.req", imem_req, 1);
            check("fetch.addr", imem_addr, model_pc);
            check("fetch.dreq", dmem_req, 0);
            quiet("fetch");
        end

        @(negedge clk);
        imem_ack = 1'b1;
        #1;
        check("decode.state", state, 2);
        check("decode.instr", instr, ins);
        check("decode.ireq", imem_req, 0);
        quiet("decode");

        @(negedge clk);
        #1;
        check("exec.state", state, 3);
        check("exec.dreq", dmem_req, 0);
        quiet("exec");

        if (rd || wr) begin
            for (int j = 0; j <= dwait; j++) begin
                @(negedge clk);
                dmem_ack   = (j == dwait);
                dmem_rdata = rdata;
                #1;
                check("mem.state", state, 4);
                check("mem.req", dmem_req, 1);
                check("mem.we", dmem_we, wr);
                check("mem.addr", dmem_addr, addr);
                check("mem.wdata", dmem_wdata, sdata);
                check("mem.ireq", imem_req, 0);
                quiet("mem");
            end
        end

        @(negedge clk);
        dmem_ack   = 1'b0;
        pc_next_in = nxt;
        halt_req   = halt;
        #1;
        check("sb.depth", 32'(sb_q.size()), 1);
        e = sb_q.pop_front();
        check("wb.state", state, 5);
        check("wb.rf_wen", rf_wen, e.rf_wen);
        check("wb.retire", retire, e.retire);
        check("wb.pc", pc, model_pc);
        check("wb.dreq", dmem_req, 0);
        if (e.chk_load) check("wb.load_data", load_data, e.load_data);
        model_pc = e.pc_after;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        rst           = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        alu_result_in = '0;
        rs2_in        = '0;
        pc_next_in    = '0;
        dmem_ack      = 1'b0;
        dmem_rdata    = '0;
        halt_req      = 1'b0;
        model_pc      = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst.state", state, 0);
        check("rst.pc", pc, 0);
        check("rst.instr", instr, 32'h0000_0013);
        check("rst.dmem_addr", dmem_addr, 0);
        check("rst.dmem_wdata", dmem_wdata, 0);
        check("rst.load_data", load_data, 0);
        check("rst.fault", fault, 0);
        check("rst.ireq", imem_req, 0);
        check("rst.dreq", dmem_req, 0);
        quiet("rst");

        // Release with imem_ack tied high: back-to-back ALU ops.
        @(negedge clk);
        rst      = 1'b1;
        imem_ack = 1'b1;
        #1;
        check("idle.state", state, 0);
        do_instr(32'h0010_0093, 0, 0, 1, 0, 0, 32'h1, 32'h0, 32'h0, 32'h4, 0);
        do_instr(32'h0020_8113, 0, 0, 1, 0, 0, 32'h3, 32'h0, 32'h0, 32'h8, 0);

        // Load with three wait cycles on the data bus.
        do_instr(32'h1000_2183, 1, 0, 1, 0, 3, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'hC, 0);

        // Store: no register write, load latch untouched.
        do_instr(32'h1030_2223, 0, 1, 0, 0, 1, 32'h104, 32'hCAFE_F00D, 32'h1234_5678, 32'h10, 0);
        check("sw.load_kept", load_data, 32'hDEAD_BEEF);

        // Halt after this instruction, then resume at the updated PC.
        do_instr(32'h0010_0093, 0, 0, 1, 0, 0, 32'h5, 32'h0, 32'h0, 32'h14, 1);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("halt.state", state, 6);
            check("halt.ireq", imem_req, 0);
            check("halt.dreq", dmem_req, 0);
            check("halt.pc", pc, 32'h14);
            quiet("halt");
        end
        @(negedge clk);
        halt_req = 1'b0;
        #1;
        check("halt.release_state", state, 6);
        do_instr(32'h0010_0093, 0, 0, 1, 1, 0, 32'h6, 32'h0, 32'h0, 32'h18, 0);

        // Misaligned jump target: link write happens, no retire, PC held.
        do_instr(32'h0060_00EF, 0, 0, 1, 0, 0, 32'h1C, 32'h0, 32'h0, 32'h6, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("align.state", state, 7);
            check("align.fault", fault, 1);
            check("align.pc", pc, 32'h18);
            check("align.ireq", imem_req, 0);
            quiet("align");
        end

        // Reset clears the fault.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst2.state", state, 0);
        check("rst2.fault", fault, 0);
        check("rst2.pc", pc, 0);

        // Fetch timeout: no ack ever.
        imem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("to.fetch_state", state, 1);
            check("to.fetch_req", imem_req, 1);
        end
        @(negedge clk);
        imem_ack = 1'b1;
        #1;
        check("to.state", state, 7);
        check("to.fault", fault, 1);
        check("to.ireq", imem_req, 0);
        @(negedge clk);
        #1;
        check("to.absorb_state", state, 7);
        check("to.absorb_req", imem_req, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("to.rst_fault", fault, 0);

        // Async reset while a load is waiting in MEM.
        dec_mem_read  = 1'b1;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b1;
        alu_result_in = 32'h200;
        dmem_ack      = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (state != 3'd4 && n < 20);
        check("ar.reach_mem", state, 4);
        check("ar.dreq_before", dmem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        check("ar.dreq_after", dmem_req, 0);
        check("ar.state", state, 0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ar.idle", state, 0);
        @(negedge clk);
        #1;
        check("ar.refetch", state, 1);
        check("ar.load_data", load_data, 0);
        check("ar.dreq_refetch", dmem_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
